// File: rtl/instr_fetch_seq_if.sv
// Bus bundle for instr_fetch_seq.
// It carries the ROM fetch port and the valid/ready instruction port towards decode.
// The master side is the sequencer. The slave side is the ROM plus the decode stage.
interface instr_fetch_seq_if;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_op;
  logic [7:0] instr_imm;
  logic       instr_has_imm;
  logic [7:0] instr_pc;

  modport master (
    output rom_addr,
    input  rom_data,
    output instr_valid,
    input  instr_ready,
    output instr_op,
    output instr_imm,
    output instr_has_imm,
    output instr_pc
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  instr_valid,
    output instr_ready,
    input  instr_op,
    input  instr_imm,
    input  instr_has_imm,
    input  instr_pc
  );
endinterface

// File: rtl/instr_fetch_seq.sv
// Fetch-side sequencer for the 8-bit instruction ROM.
// It owns the PC, which is rom_addr itself, and assembles 1- and 2-byte instructions.
// JUMP and NOP are executed locally. Every other instruction is handed to decode
// over a registered valid/ready handshake.
module instr_fetch_seq #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  instr_fetch_seq_if.master bus
);

  typedef enum logic [2:0] {
    REQ_OP,
    CAP_OP,
    REQ_IMM,
    CAP_IMM,
    EMIT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] op_q, op_d;
  logic [7:0] imm_q, imm_d;
  logic       has_imm_q, has_imm_d;
  logic [7:0] pc_q, pc_d;
  logic       valid_q, valid_d;

  // LOAD (Bx) and JUMP (Cx) carry an operand byte.
  function automatic logic is_two_byte(input logic [7:0] op);
    return (op[7:4] == 4'b1011) || (op[7:4] == 4'b1100);
  endfunction

  function automatic logic is_jump(input logic [7:0] op);
    return op[7:4] == 4'b1100;
  endfunction

  // Next-state and datapath update for the fetch FSM.
  // NOTE: every signal written in this block takes its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    op_d      = op_q;
    imm_d     = imm_q;
    has_imm_d = has_imm_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    unique case (state_q)
      REQ_OP: begin
        if (run) state_d = CAP_OP;
      end
      CAP_OP: begin
        op_d = bus.rom_data;
        pc_d = addr_q;
        if (is_two_byte(bus.rom_data)) begin
          // The operand lives at PC+1. This wraps 8'hFF to 8'h00.
          addr_d  = addr_q + 8'd1;
          state_d = REQ_IMM;
        end else if (bus.rom_data == 8'hFF) begin
          addr_d  = addr_q + 8'd1;
          state_d = REQ_OP;
        end else begin
          imm_d     = 8'h00;
          has_imm_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = EMIT;
        end
      end
      REQ_IMM: begin
        // This cycle only covers the one-cycle ROM read latency.
        state_d = CAP_IMM;
      end
      CAP_IMM: begin
        imm_d     = bus.rom_data;
        has_imm_d = 1'b1;
        if (is_jump(op_q)) begin
          addr_d  = bus.rom_data;
          state_d = REQ_OP;
        end else begin
          valid_d = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        // Hold every output until decode accepts the instruction. A stall can last indefinitely.
        if (bus.instr_ready) begin
          valid_d = 1'b0;
          addr_d  = addr_q + 8'd1;
          state_d = REQ_OP;
        end
      end
      default: begin
        state_d = REQ_OP;
      end
    endcase
  end

  // State and datapath registers. Reset drops any pending emit immediately.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= REQ_OP;
      addr_q    <= RESET_PC;
      op_q      <= 8'h00;
      imm_q     <= 8'h00;
      has_imm_q <= 1'b0;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      has_imm_q <= has_imm_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.rom_addr      = addr_q;
  assign bus.instr_valid   = valid_q;
  assign bus.instr_op      = op_q;
  assign bus.instr_imm     = imm_q;
  assign bus.instr_has_imm = has_imm_q;
  assign bus.instr_pc      = pc_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq.
// Instance u_dut0 uses RESET_PC=00 with a synchronous ROM model.
// Instance u_dut1 uses RESET_PC=FF to exercise address wrap.
// Expected emits are queued when a program is loaded and popped on each handshake.
module tb_instr_fetch_seq;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] imm;
    logic       has_imm;
    logic [7:0] pc;
  } emit_t;

  logic clk;
  logic rst_n;
  logic run0;
  logic run1;

  instr_fetch_seq_if if0 ();
  instr_fetch_seq_if if1 ();

  instr_fetch_seq #(.RESET_PC(8'h00)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run0),
    .bus   (if0.master)
  );

  instr_fetch_seq #(.RESET_PC(8'hFF)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run1),
    .bus   (if1.master)
  );

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_emit  = 0;
  emit_t exp_q [$];

  // Snapshot state used by the monitor's stall check.
  logic        mon_en    = 1'b0;
  logic        have_prev = 1'b0;
  logic        prev_vld;
  logic        prev_rdy;
  logic [33:0] prev_snap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROMs: data appears the cycle after the address is sampled.
  always @(posedge clk) if0.rom_data <= mem0[if0.rom_addr];
  always @(posedge clk) if1.rom_data <= mem1[if1.rom_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor for u_dut0, sampled on the falling edge.
  // A cycle with valid and ready set transfers one instruction, which must match the queue head.
  // A cycle with valid set and ready clear must leave every output frozen at the next sample.
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && prev_vld && !prev_rdy)
        check("stall_frozen",
              {if0.instr_valid, if0.instr_op, if0.instr_imm, if0.instr_has_imm, if0.instr_pc},
              prev_snap[33:1] == 33'd0 ? 64'd0 : {30'd0, prev_snap});
      if (if0.instr_valid && if0.instr_ready) begin
        n_emit++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_emit: got op=%0h pc=%0h, expected no emit", if0.instr_op, if0.instr_pc);
        end else begin
          emit_t e;
          e = exp_q.pop_front();
          check("emit", {if0.instr_op, if0.instr_imm, if0.instr_has_imm, if0.instr_pc}, e);
        end
      end
      have_prev = 1'b1;
      prev_vld  = if0.instr_valid;
      prev_rdy  = if0.instr_ready;
      prev_snap = {if0.instr_valid, if0.instr_op, if0.instr_imm, if0.instr_has_imm, if0.instr_pc};
    end
  end

  // Freezing of rom_addr during a stall, sampled the same way as the outputs.
  logic       addr_prev_ok = 1'b0;
  logic [7:0] addr_prev;
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      addr_prev_ok = 1'b0;
    end else begin
      if (addr_prev_ok) check("stall_addr_frozen", if0.rom_addr, addr_prev);
      addr_prev_ok = if0.instr_valid && !if0.instr_ready;
      addr_prev    = if0.rom_addr;
    end
  end

  task automatic clear_mem0();
    for (int i = 0; i < 256; i++) mem0[i] = 8'h00;
  endtask

  // Holds both DUTs in reset while the caller loads ROM contents, then releases away from a clock edge.
  task automatic start_reset();
    rst_n = 1'b0;
    run0  = 1'b0;
    if0.instr_ready = 1'b0;
    clear_mem0();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  localparam int N_MAIN = 6;
  logic [7:0] prog [24];
  emit_t      vecs [N_MAIN];

  initial begin
    int k;
    int emit_base;

    // The main program exercises LOAD, plain ops, NOP skip, JUMP redirect, then a self-JUMP parking loop.
    prog = '{8'hB2, 8'h05, 8'h08, 8'hFF, 8'hB1, 8'hAA, 8'hC0, 8'h10,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h3A, 8'hBF, 8'hFF, 8'h00, 8'hC0, 8'h14, 8'h00, 8'h00};
    vecs[0] = '{op: 8'hB2, imm: 8'h05, has_imm: 1'b1, pc: 8'h00};
    vecs[1] = '{op: 8'h08, imm: 8'h00, has_imm: 1'b0, pc: 8'h02};
    vecs[2] = '{op: 8'hB1, imm: 8'hAA, has_imm: 1'b1, pc: 8'h04};
    vecs[3] = '{op: 8'h3A, imm: 8'h00, has_imm: 1'b0, pc: 8'h10};
    vecs[4] = '{op: 8'hBF, imm: 8'hFF, has_imm: 1'b1, pc: 8'h11};
    vecs[5] = '{op: 8'h00, imm: 8'h00, has_imm: 1'b0, pc: 8'h13};

    // u_dut1 program: FF:B0 00:3C, then a self-jump at 01.
    for (int i = 0; i < 256; i++) mem1[i] = 8'h00;
    mem1[8'hFF] = 8'hB0;
    mem1[8'h00] = 8'h3C;
    mem1[8'h01] = 8'hC0;
    mem1[8'h02] = 8'h01;
    run1 = 1'b0;
    if1.instr_ready = 1'b0;

    // Reset values.
    start_reset();
    for (int i = 0; i < 24; i++) mem0[i] = prog[i];
    #12;
    check("rst_valid",   if0.instr_valid,   1'b0);
    check("rst_addr",    if0.rom_addr,      8'h00);
    check("rst_op",      if0.instr_op,      8'h00);
    check("rst_imm",     if0.instr_imm,     8'h00);
    check("rst_has_imm", if0.instr_has_imm, 1'b0);
    check("rst_pc",      if0.instr_pc,      8'h00);
    check("rst1_addr",   if1.rom_addr,      8'hFF);
    check("rst1_pc",     if1.instr_pc,      8'hFF);
    release_reset();

    // With run low the sequencer stays parked on the reset PC.
    cycles(6);
    check("run0_addr_held", if0.rom_addr,    8'h00);
    check("run0_no_valid",  if0.instr_valid, 1'b0);

    // Table-driven main program with random backpressure.
    for (int i = 0; i < N_MAIN; i++) exp_q.push_back(vecs[i]);
    emit_base = n_emit;
    mon_en = 1'b1;
    run0   = 1'b1;
    repeat (220) begin
      @(posedge clk);
      #1;
      if0.instr_ready = 1'($urandom_range(0, 1));
    end
    check("main_queue_drained", exp_q.size(), 0);
    check("main_emit_count",    n_emit - emit_base, N_MAIN);

    // Ten-cycle stall in EMIT must produce exactly one transfer per instruction.
    start_reset();
    mem0[0] = 8'h08;
    mem0[1] = 8'h09;
    mem0[2] = 8'hC0;
    mem0[3] = 8'h02;
    exp_q.delete();
    exp_q.push_back('{op: 8'h08, imm: 8'h00, has_imm: 1'b0, pc: 8'h00});
    exp_q.push_back('{op: 8'h09, imm: 8'h00, has_imm: 1'b0, pc: 8'h01});
    release_reset();
    run0 = 1'b1;
    emit_base = n_emit;
    for (k = 0; k < 20 && !if0.instr_valid; k++) cycles(1);
    check("stall_wait_valid", if0.instr_valid, 1'b1);
    cycles(10);
    check("stall_addr_after",  if0.rom_addr,    8'h00);
    check("stall_valid_after", if0.instr_valid, 1'b1);
    check("stall_no_transfer", n_emit - emit_base, 0);
    if0.instr_ready = 1'b1;
    cycles(20);
    check("stall_queue_drained", exp_q.size(), 0);
    check("stall_emit_count",    n_emit - emit_base, 2);

    // Reset asserted while an emit is pending drops it at once.
    start_reset();
    mem0[0] = 8'h08;
    mem0[1] = 8'hC0;
    mem0[2] = 8'h01;
    release_reset();
    run0 = 1'b1;
    for (k = 0; k < 20 && !if0.instr_valid; k++) cycles(1);
    check("rstmid_wait_valid", if0.instr_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", if0.instr_valid, 1'b0);
    check("rstmid_addr",  if0.rom_addr,    8'h00);
    check("rstmid_op",    if0.instr_op,    8'h00);
    #10;

    // JUMP from 09 to 05 becomes visible four edges after REQ_OP at 09.
    start_reset();
    mem0[8'h00] = 8'hC0;
    mem0[8'h01] = 8'h09;
    mem0[8'h09] = 8'hC0;
    mem0[8'h0A] = 8'h05;
    mem0[8'h05] = 8'hC0;
    mem0[8'h06] = 8'h05;
    exp_q.delete();
    if0.instr_ready = 1'b1;
    release_reset();
    run0 = 1'b1;
    emit_base = n_emit;
    for (k = 0; k < 20 && if0.rom_addr != 8'h09; k++) cycles(1);
    check("jump_reach_09", if0.rom_addr, 8'h09);
    cycles(3);
    check("jump_operand_addr", if0.rom_addr, 8'h0A);
    cycles(1);
    check("jump_target_addr", if0.rom_addr, 8'h05);
    cycles(10);
    check("jump_no_emit", n_emit - emit_base, 0);

    // With RESET_PC at FF, the operand is fetched from 00 and the next fetch is from 01.
    run1 = 1'b1;
    if1.instr_ready = 1'b1;
    for (k = 0; k < 20 && !if1.instr_valid; k++) cycles(1);
    check("wrap_valid",   if1.instr_valid, 1'b1);
    check("wrap_emit",    {if1.instr_op, if1.instr_imm, if1.instr_has_imm, if1.instr_pc},
                          {8'hB0, 8'h3C, 1'b1, 8'hFF});
    cycles(1);
    check("wrap_next_addr", if1.rom_addr,    8'h01);
    check("wrap_valid_low", if1.instr_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
